rx_arp_classifier: RTL

//  GMII-style receive-stream classifier that sits directly upstream of post_switch.

---
 rtl/rx_arp_classifier.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/rx_arp_classifier.sv
// Receive-stream ARP classifier: passes the GMII-style stream through a DELAY-deep
// line and tags each frame whose EtherType is 0x0806 from its first output cycle.
module rx_arp_classifier #(
    parameter int unsigned DELAY = 48
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       speed,
    input  logic [7:0] up_data,
    input  logic       up_dv,
    input  logic       up_er,
    output logic [7:0] down_data,
    output logic       down_dv,
    output logic       down_er,
    output logic       down_sof,
    output logic       down_arp
);

    localparam int unsigned ID_W     = 2;
    localparam int unsigned N_TAGS   = 4;
    localparam int unsigned LINE_W   = ID_W + 10;
    localparam int unsigned ER_BIT   = 8;
    localparam int unsigned DV_BIT   = 9;
    localparam int unsigned ID_LO    = 10;
    localparam int unsigned ID_HI    = LINE_W - 1;
    localparam int unsigned LAST     = DELAY - 1;
    localparam int unsigned HEAD     = DELAY - 2;
    localparam int unsigned CNT_W    = 4;
    localparam int unsigned TYPE_HI  = 12;
    localparam int unsigned TYPE_LO  = 13;

    typedef enum logic [2:0] {
        S_WAIT,
        S_IDLE,
        S_PRE,
        S_HDR,
        S_BODY,
        S_ABORT
    } state_t;

    state_t             state_q;
    logic               dv_q;
    logic [ID_W-1:0]    id_q;
    logic [N_TAGS-1:0]  tag_q;
    logic               phase_q;
    logic [3:0]         low_q;
    logic [CNT_W-1:0]   hdr_cnt_q;
    logic               type_hi_ok_q;
    logic [LINE_W-1:0]  line_q [DELAY];
    logic               sof_q;
    logic               arp_q;

    logic               rise_c;
    logic               phase_eff_c;
    logic [ID_W-1:0]    id_next_c;
    logic               sym_pre_c;
    logic               sym_sfd_c;
    logic               byte_vld_c;
    logic [7:0]         byte_c;
    logic               head_rise_c;
    logic               head_dv_c;
    logic [ID_W-1:0]    head_id_c;

    // Symbol decode: frame-start detection, nibble pairing and preamble/SFD matching.
    always_comb begin
        rise_c      = up_dv && !dv_q;
        phase_eff_c = rise_c ? 1'b0 : phase_q;
        id_next_c   = rise_c ? id_q + 2'd1 : id_q;
        sym_pre_c   = speed ? (up_data == 8'h55) : (up_data[3:0] == 4'h5);
        sym_sfd_c   = speed ? ((up_data == 8'hD5) || (up_data == 8'h5D))
                            : (up_data[3:0] == 4'hD);
        byte_vld_c  = speed ? up_dv : (up_dv && phase_eff_c);
        byte_c      = speed ? up_data : {up_data[3:0], low_q};
    end

    // Classification FSM, frame ID counter and tag table.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_WAIT;
            dv_q         <= 1'b0;
            id_q         <= '0;
            tag_q        <= '0;
            phase_q      <= 1'b0;
            low_q        <= '0;
            hdr_cnt_q    <= '0;
            type_hi_ok_q <= 1'b0;
        end else begin
            dv_q <= up_dv;
            id_q <= id_next_c;
            if (up_dv) begin
                phase_q <= ~phase_eff_c;
                if (!phase_eff_c) begin
                    low_q <= up_data[3:0];
                end
            end
            if (rise_c) begin
                tag_q[id_next_c] <= 1'b0;
            end
            if (!up_dv) begin
                state_q <= S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        state_q <= sym_pre_c ? S_PRE : S_ABORT;
                    end
                    S_PRE: begin
                        if (sym_pre_c) begin
                            state_q <= S_PRE;
                        end else if (sym_sfd_c) begin
                            // Header bytes pair nibbles from the symbol after the SFD.
                            state_q   <= S_HDR;
                            hdr_cnt_q <= '0;
                            phase_q   <= 1'b0;
                        end else begin
                            state_q <= S_ABORT;
                        end
                    end
                    S_HDR: begin
                        if (byte_vld_c) begin
                            hdr_cnt_q <= hdr_cnt_q + 4'd1;
                            if (hdr_cnt_q == CNT_W'(TYPE_HI)) begin
                                type_hi_ok_q <= (byte_c == 8'h08);
                            end
                            if (hdr_cnt_q == CNT_W'(TYPE_LO)) begin
                                tag_q[id_q] <= type_hi_ok_q && (byte_c == 8'h06);
                                state_q     <= S_BODY;
                            end
                        end
                    end
                    default: begin
                        state_q <= state_q;
                    end
                endcase
            end
        end
    end

    // Head of the line one stage before the output: decides sof/arp for the next cycle.
    always_comb begin
        head_dv_c   = line_q[HEAD][DV_BIT];
        head_rise_c = head_dv_c && !line_q[LAST][DV_BIT];
        head_id_c   = line_q[HEAD][ID_HI:ID_LO];
    end

    // Delay line carrying {id, dv, er, data}, plus frame-aligned sof/arp registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DELAY; i++) begin
                line_q[i] <= '0;
            end
            sof_q <= 1'b0;
            arp_q <= 1'b0;
        end else begin
            line_q[0] <= {id_next_c, up_dv, up_er, up_data};
            for (int unsigned i = 1; i < DELAY; i++) begin
                line_q[i] <= line_q[i-1];
            end
            sof_q <= head_rise_c;
            if (head_rise_c) begin
                arp_q <= tag_q[head_id_c];
            end else if (!head_dv_c) begin
                arp_q <= 1'b0;
            end
        end
    end

    assign down_data = line_q[LAST][7:0];
    assign down_er   = line_q[LAST][ER_BIT];
    assign down_dv   = line_q[LAST][DV_BIT];
    assign down_sof  = sof_q;
    assign down_arp  = arp_q;

endmodule
